pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage fetch/decode/execute/memory/writeback pipeline.
//  Generates per-stage stall/flush/bubble controls and EX operand forwarding selects.
//  Resolves load-use hazards, EX branch redirects and multi-cycle data-memory waits.
//  Instantiated beside the stages in riscv_pipeline; drives their enable/flush inputs.
// PARAMETERS
//  MEM_TIMEOUT  default 255  max consecutive mem wait cycles before the timeout trap
//  CNT_W        default 32   width of performance counters (when compiled in)
// PORTS
//  clk            in   1   pipeline clock
//  reset          in   1   asynchronous, active-high reset
//  de_rs1/de_rs2  in   5   source regs of instruction in DE
//  de_use_rs1/2   in   1   DE instruction actually reads rs1/rs2
//  ex_rs1/ex_rs2  in   5   source regs of instruction in EX
//  ex_rd          in   5   EX dest reg; ex_we in 1 (writes rd); ex_is_load in 1
//  mem_rd         in   5   MEM dest reg; mem_we in 1
//  wb_rd          in   5   WB dest reg; wb_we in 1
//  ex_redirect    in   1   EX resolved taken branch/jump (target travels in datapath)
//  mem_req        in   1   MEM stage data access in flight
//  mem_ready      in   1   data memory completes access this cycle
//  stall_fe       out  1   hold PC / fe_to_de register
//  stall_de       out  1   hold de_to_ex register inputs (DE instruction)
//  stall_ex       out  1   hold ex_to_mem register
//  stall_mem      out  1   hold mem_to_wb register
//  flush_de       out  1   invalidate fe_to_de register next edge
//  bubble_ex      out  1   load NOP into de_to_ex register next edge
//  bubble_wb      out  1   load NOP into mem_to_wb (wb_en=0) next edge
//  fwd_a/fwd_b    out  2   EX operand select: 00 regfile, 01 MEM result, 10 WB data
//  mem_timeout    out  1   sticky trap: memory wait exceeded MEM_TIMEOUT
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, mem_timeout=0; all stall/flush/bubble outputs 0; fwd=00.
//  FSM states RUN, MEM_WAIT, HALT (ctrl_state_e).
//  RUN: mem_req&!mem_ready -> MEM_WAIT this cycle, wait_cnt<=1; else evaluate hazards.
//  MEM_WAIT: stall_fe/de/ex/mem=1, bubble_wb=1; wait_cnt++ per cycle;
//   mem_ready -> RUN (outputs of that cycle = RUN-mode, stalls released same cycle);
//   wait_cnt==MEM_TIMEOUT & !mem_ready -> HALT.
//  HALT: all stalls=1, bubble_wb=1, mem_timeout=1; left only by reset.
//  Priority in RUN (highest first): mem wait > ex_redirect > load-use.
//  Redirect: flush_de=1, bubble_ex=1, no stalls; squashes any load-use on the DE instr.
//  Load-use: ex_is_load&ex_we&ex_rd!=0&((de_use_rs1&de_rs1==ex_rd)|(de_use_rs2&de_rs2==ex_rd))
//   -> stall_fe=stall_de=1, bubble_ex=1 for exactly one cycle (bubble removes re-detect).
//  Forwarding (combinational, per operand): src==0 -> 00; mem_we&mem_rd==src -> 01;
//   else wb_we&wb_rd==src -> 10; else 00. MEM beats WB. Held stable during stalls.
//  Redirect during MEM_WAIT: EX is frozen, redirect honoured on the release cycle.
//  Reset mid-wait: immediate return to RUN, counters cleared, no stall outputs.
// CONFIGURATION
//  PIPE_HAZARD_PERF_EN defined: adds outputs perf_stall_cnt, perf_flush_cnt, perf_memw_cnt
//   (CNT_W each): count load-use stall cycles, redirects, MEM_WAIT cycles; saturate at
//   all-ones; cleared by reset. Undefined: ports and counters absent, no other change.
// STRUCTURE
//  riscv_structures.sv: ctrl_state_e {RUN,MEM_WAIT,HALT}, fwd_sel_e {FWD_RF=2'b00,
//   FWD_MEM=2'b01,FWD_WB=2'b10}, localparam REG_X0=5'd0.
//  Sub-module fwd_unit: combinational forwarding select, instantiated once per operand.
//  Top holds FSM, wait counter, hazard priority logic, optional perf counters.
// TESTING
//  ex_rd=5,ex_is_load=1,ex_we=1,de_rs1=5,de_use_rs1=1 -> 1 cycle stall_fe/de=1,bubble_ex=1.
//  Same as above but ex_rd=0 -> no stall, no bubble.
//  ex_redirect=1 with load-use present -> flush_de=1,bubble_ex=1, stall_fe=stall_de=0.
//  ex_rs1=7, mem_rd=7 mem_we=1, wb_rd=7 wb_we=1 -> fwd_a=01; mem_we=0 -> fwd_a=10.
//  mem_req=1, mem_ready low 3 cycles -> 3 cycles all stalls+bubble_wb, release on ready.
//  MEM_TIMEOUT=4, mem_ready never -> HALT, mem_timeout=1 sticky; reset -> RUN, all 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Optional perf counters are compiled in with PIPE_HAZARD_PERF_EN.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bundle between the pipeline stages (master) and the controller (slave).
// Carries stage register ids, memory handshake and the stall/flush/forward controls.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [4:0] de_rs1;
    logic [4:0] de_rs2;
    logic       de_use_rs1;
    logic       de_use_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_we;
    logic       ex_is_load;
    logic [4:0] mem_rd;
    logic       mem_we;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic       ex_redirect;
    logic       mem_req;
    logic       mem_ready;

    logic       stall_fe;
    logic       stall_de;
    logic       stall_ex;
    logic       stall_mem;
    logic       flush_de;
    logic       bubble_ex;
    logic       bubble_wb;
    fwd_sel_e   fwd_a;
    fwd_sel_e   fwd_b;
    logic       mem_timeout;

    modport master (
        output de_rs1, de_rs2, de_use_rs1, de_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_we, ex_is_load,
        output mem_rd, mem_we, wb_rd, wb_we,
        output ex_redirect, mem_req, mem_ready,
        input  stall_fe, stall_de, stall_ex, stall_mem,
        input  flush_de, bubble_ex, bubble_wb,
        input  fwd_a, fwd_b, mem_timeout
    );

    modport slave (
        input  de_rs1, de_rs2, de_use_rs1, de_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_we, ex_is_load,
        input  mem_rd, mem_we, wb_rd, wb_we,
        input  ex_redirect, mem_req, mem_ready,
        output stall_fe, stall_de, stall_ex, stall_mem,
        output flush_de, bubble_ex, bubble_wb,
        output fwd_a, fwd_b, mem_timeout
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX operand forwarding select for one source register.
// The younger MEM result takes precedence over WB data.
module pipeline_hazard_ctrl_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_we_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_we_i,
    output fwd_sel_e   sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (src_i != REG_X0) begin
            if (mem_we_i && (mem_rd_i == src_i)) begin
                sel_o = FWD_MEM;
            end else if (wb_we_i && (wb_rd_i == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencing: mem-wait FSM, redirect/load-use priority, forwarding.
// Define PIPE_HAZARD_PERF_EN to add saturating stall/flush/mem-wait counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
`ifdef PIPE_HAZARD_PERF_EN
   ,parameter int CNT_W       = 32
`endif
)(
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_PERF_EN
   ,output logic [CNT_W-1:0]     perf_stall_cnt,
    output logic [CNT_W-1:0]     perf_flush_cnt,
    output logic [CNT_W-1:0]     perf_memw_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_MEMW = MEM_WAIT;
    localparam logic [1:0] S_HALT = HALT;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              run_mode;
    logic              mem_hold;
    logic              load_use;
    logic              redir;
    logic              lu_stall;
    fwd_sel_e          fwd_a_w, fwd_b_w;

    assign load_use = hz.ex_is_load && hz.ex_we
                   && (hz.ex_rd != REG_X0)
                   && ((hz.de_use_rs1 && (hz.de_rs1 == hz.ex_rd))
                    || (hz.de_use_rs2 && (hz.de_rs2 == hz.ex_rd)));

    // The release cycle of a wait evaluates hazards as in RUN.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        run_mode = 1'b0;
        mem_hold = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    state_d  = S_MEMW;
                    wait_d   = WAIT_W'(1);
                    mem_hold = 1'b1;
                end else begin
                    run_mode = 1'b1;
                end
            end
            S_MEMW: begin
                if (hz.mem_ready) begin
                    state_d  = S_RUN;
                    wait_d   = '0;
                    run_mode = 1'b1;
                end else begin
                    mem_hold = 1'b1;
                    if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = S_HALT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            S_HALT: begin
                mem_hold = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign redir    = !reset && run_mode && hz.ex_redirect;
    assign lu_stall = !reset && run_mode && !hz.ex_redirect && load_use;

    assign hz.stall_fe    = (!reset && mem_hold) || lu_stall;
    assign hz.stall_de    = (!reset && mem_hold) || lu_stall;
    assign hz.stall_ex    = !reset && mem_hold;
    assign hz.stall_mem   = !reset && mem_hold;
    assign hz.bubble_wb   = !reset && mem_hold;
    assign hz.flush_de    = redir;
    assign hz.bubble_ex   = redir || lu_stall;
    assign hz.mem_timeout = !reset && (state_q == S_HALT);

    pipeline_hazard_ctrl_fwd_unit u_fwd_a (
        .src_i    (hz.ex_rs1),
        .mem_rd_i (hz.mem_rd),
        .mem_we_i (hz.mem_we),
        .wb_rd_i  (hz.wb_rd),
        .wb_we_i  (hz.wb_we),
        .sel_o    (fwd_a_w)
    );

    pipeline_hazard_ctrl_fwd_unit u_fwd_b (
        .src_i    (hz.ex_rs2),
        .mem_rd_i (hz.mem_rd),
        .mem_we_i (hz.mem_we),
        .wb_rd_i  (hz.wb_rd),
        .wb_we_i  (hz.wb_we),
        .sel_o    (fwd_b_w)
    );

    assign hz.fwd_a = reset ? FWD_RF : fwd_a_w;
    assign hz.fwd_b = reset ? FWD_RF : fwd_b_w;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memw_cnt_q;
    logic             memw_cyc;

    assign memw_cyc = !reset && mem_hold && (state_q != S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            memw_cnt_q  <= '0;
        end else begin
            if (lu_stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redir && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (memw_cyc && !(&memw_cnt_q)) begin
                memw_cnt_q <= memw_cnt_q + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_memw_cnt  = memw_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic
// checked against a cycle-count reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int MT = 4;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: stalled cycles in current wait, halted flag
    int   m_waited;
    bit   m_halted;
    bit   m_wait_now;
    bit   m_rst;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (hz.mem_we && hz.mem_rd == src) return 2'b01;
        if (hz.wb_we && hz.wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clr_in();
        hz.de_rs1 = 0; hz.de_rs2 = 0;
        hz.de_use_rs1 = 0; hz.de_use_rs2 = 0;
        hz.ex_rs1 = 0; hz.ex_rs2 = 0; hz.ex_rd = 0;
        hz.ex_we = 0; hz.ex_is_load = 0;
        hz.mem_rd = 0; hz.mem_we = 0;
        hz.wb_rd = 0; hz.wb_we = 0;
        hz.ex_redirect = 0;
        hz.mem_req = 0; hz.mem_ready = 0;
    endtask

    // Settle, then compare every output with the model.
    task automatic settle();
        logic [7:0] exp_ctl, got_ctl;
        logic [1:0] ea, eb;
        bit lu;
        #3;
        m_rst = reset;
        m_wait_now = 0;
        exp_ctl = '0;
        ea = ref_fwd(hz.ex_rs1);
        eb = ref_fwd(hz.ex_rs2);
        lu = hz.ex_is_load && hz.ex_we && hz.ex_rd != 0 &&
             ((hz.de_use_rs1 && hz.de_rs1 == hz.ex_rd) ||
              (hz.de_use_rs2 && hz.de_rs2 == hz.ex_rd));
        // {sfe,sde,sex,smem,flush,bex,bwb,timeout}
        if (reset) begin
            ea = 0; eb = 0;
        end else if (m_halted) begin
            exp_ctl = 8'b1111_0011;
        end else if ((m_waited > 0 || hz.mem_req) && !hz.mem_ready) begin
            m_wait_now = 1;
            exp_ctl = 8'b1111_0010;
        end else if (hz.ex_redirect) begin
            exp_ctl = 8'b0000_1100;
        end else if (lu) begin
            exp_ctl = 8'b1100_0100;
        end
        got_ctl = {hz.stall_fe, hz.stall_de, hz.stall_ex, hz.stall_mem,
                   hz.flush_de, hz.bubble_ex, hz.bubble_wb, hz.mem_timeout};
        chk("ctl", 32'(got_ctl), 32'(exp_ctl));
        chk("fwd_a", 32'(hz.fwd_a), 32'(ea));
        chk("fwd_b", 32'(hz.fwd_b), 32'(eb));
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_rst) begin
            m_waited = 0;
            m_halted = 0;
        end else if (!m_halted) begin
            if (m_wait_now) begin
                m_waited++;
                if (m_waited == MT + 1) m_halted = 1;
            end else begin
                m_waited = 0;
            end
        end
        #1;
    endtask

    initial begin
        int nst;
        n_chk = 0; n_err = 0;
        m_waited = 0; m_halted = 0;
        clr_in();
        reset = 1'b1;
        @(posedge clk); #1;

        // reset state, even with a hazard on the inputs
        hz.ex_rd = 5; hz.ex_is_load = 1; hz.ex_we = 1;
        hz.de_rs1 = 5; hz.de_use_rs1 = 1; hz.ex_rs1 = 5;
        hz.mem_rd = 5; hz.mem_we = 1;
        settle();
        chk("rst_sfe", 32'(hz.stall_fe), 0);
        chk("rst_fwd", 32'(hz.fwd_a), 0);
        tick();
        reset = 1'b0;
        clr_in();
        settle(); tick();

        // load-use stall, then bubble in EX clears it
        hz.ex_rd = 5; hz.ex_is_load = 1; hz.ex_we = 1;
        hz.de_rs1 = 5; hz.de_use_rs1 = 1;
        settle();
        chk("lu_sfe", 32'(hz.stall_fe), 1);
        chk("lu_sde", 32'(hz.stall_de), 1);
        chk("lu_bex", 32'(hz.bubble_ex), 1);
        chk("lu_sex", 32'(hz.stall_ex), 0);
        tick();
        hz.ex_is_load = 0; hz.ex_we = 0; hz.ex_rd = 0;
        settle();
        chk("lu_once", 32'(hz.stall_fe), 0);
        tick();

        // load to x0 is no hazard
        hz.ex_rd = 0; hz.ex_is_load = 1; hz.ex_we = 1;
        hz.de_rs1 = 0;
        settle();
        chk("x0_sfe", 32'(hz.stall_fe), 0);
        chk("x0_bex", 32'(hz.bubble_ex), 0);
        tick();

        // redirect squashes load-use
        hz.ex_rd = 5; hz.de_rs1 = 5; hz.ex_redirect = 1;
        settle();
        chk("rd_flush", 32'(hz.flush_de), 1);
        chk("rd_bex", 32'(hz.bubble_ex), 1);
        chk("rd_sfe", 32'(hz.stall_fe), 0);
        tick();
        clr_in();

        // forwarding priority
        hz.ex_rs1 = 7; hz.mem_rd = 7; hz.mem_we = 1;
        hz.wb_rd = 7; hz.wb_we = 1;
        settle();
        chk("fwd_mem", 32'(hz.fwd_a), 1);
        hz.mem_we = 0;
        settle();
        chk("fwd_wb", 32'(hz.fwd_a), 2);
        tick();
        clr_in();

        // three wait cycles, release on ready
        hz.mem_req = 1;
        nst = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            nst += int'(hz.stall_ex && hz.bubble_wb);
            tick();
            hz.mem_req = 0;
        end
        chk("mw_cycles", 32'(nst), 3);
        hz.mem_ready = 1;
        settle();
        chk("mw_release", 32'(hz.stall_fe), 0);
        tick();
        clr_in();

        // timeout: MT+1 stalled cycles then sticky halt
        hz.mem_req = 1;
        for (int i = 0; i < MT + 1; i++) begin
            settle();
            if (i == MT) chk("to_pre", 32'(hz.mem_timeout), 0);
            tick();
        end
        settle();
        chk("to_halt", 32'(hz.mem_timeout), 1);
        tick();
        hz.mem_ready = 1;
        settle();
        chk("to_sticky", 32'(hz.mem_timeout), 1);
        chk("to_stall", 32'(hz.stall_mem), 1);
        tick();
        reset = 1'b1;
        settle();
        chk("to_rst", 32'(hz.stall_fe), 0);
        tick();
        reset = 1'b0;
        clr_in();
        settle();
        chk("to_clear", 32'(hz.mem_timeout), 0);
        tick();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            hz.de_rs1 = 5'($urandom_range(0, 3));
            hz.de_rs2 = 5'($urandom_range(0, 3));
            hz.de_use_rs1 = 1'($urandom_range(0, 1));
            hz.de_use_rs2 = 1'($urandom_range(0, 1));
            hz.ex_rs1 = 5'($urandom_range(0, 3));
            hz.ex_rs2 = 5'($urandom_range(0, 3));
            hz.ex_rd = 5'($urandom_range(0, 3));
            hz.ex_we = 1'($urandom_range(0, 1));
            hz.ex_is_load = 1'($urandom_range(0, 1));
            hz.mem_rd = 5'($urandom_range(0, 3));
            hz.mem_we = 1'($urandom_range(0, 1));
            hz.wb_rd = 5'($urandom_range(0, 3));
            hz.wb_we = 1'($urandom_range(0, 1));
            hz.ex_redirect = ($urandom_range(0, 3) == 0);
            hz.mem_req = ($urandom_range(0, 3) == 0);
            hz.mem_ready = 1'($urandom_range(0, 1));
            reset = (m_halted && $urandom_range(0, 3) == 0) ||
                    ($urandom_range(0, 199) == 0);
            settle();
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
